alu_iter: RTL
=============

ALU_ITER -- requirements
Module: alu_iter

Interface
- REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 32, 64).
- REQ-002 SHALL have ports, in order:
  - clk  input  1  rising-edge clock.
  - rst  input  1  reset, asynchronous, active-high.
  - in_valid  input  1  operation offered.
  - in_ready  output  1  operation accepted when in_valid and in_ready are both high.
  - src_a  input  XLEN  operand A.
  - src_b  input  XLEN  operand B.
  - alu_op  input  alu_op_e  operation select.
  - flush  input  1  abort the in-flight operation.
  - out_valid  output  1  result available.
  - out_ready  input  1  consumer takes the result when out_valid and out_ready are both high.
  - result  output  XLEN  registered result.

Function
- REQ-003 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
- REQ-004 Base ops SHALL use ADD, SUB, AND, OR, XOR, SLL, SLT, SLTU, SRL, SRA.
  - Shift amount is src_b[$clog2(XLEN)-1:0].
  - SLT/SLTU return 1 or 0, zero-extended.
- REQ-005 Base op accepted in IDLE SHALL go to DONE with result registered; out_valid is high the next cycle (latency 1).
- REQ-006 M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) accepted SHALL go to BUSY and run a radix-2 iteration, one bit per cycle.
  - Go to DONE after exactly XLEN iterations.
  - out_valid is high XLEN+1 cycles after acceptance.
  - Latency is independent of operand values.
- REQ-007 MUL SHALL return the low XLEN bits of the product.
  - MULH returns the high XLEN bits, signed x signed.
  - MULHSU returns the high XLEN bits, signed x unsigned.
  - MULHU returns the high XLEN bits, unsigned x unsigned.
- REQ-008 DIV/REM SHALL truncate toward zero; the remainder sign follows the dividend.
- REQ-009 Divide by zero SHALL return:
  - quotient all-ones (DIV and DIVU);
  - remainder = src_a (REM and REMU).
- REQ-010 Signed overflow (most-negative / -1) SHALL return quotient = most-negative and remainder = 0.
- REQ-011 in_ready SHALL be high in IDLE, or in DONE when out_ready is high; it is forced low while flush is high.
- REQ-012 Accepting a new op in the same cycle the DONE result is consumed SHALL be back-to-back with no bubble.
- REQ-013 While out_valid is high and out_ready is low, result SHALL hold stable and the FSM SHALL stay in DONE.
- REQ-014 DONE with out_ready high and no new acceptance SHALL return to IDLE.
- REQ-015 flush SHALL move any state to IDLE on the next edge:
  - the in-flight op is discarded;
  - out_valid drops and the result is never delivered;
  - flush has priority over all other events.
- REQ-016 An undefined alu_op SHALL complete as a base op with result 0.

Reset
- REQ-017 rst high SHALL asynchronously force: state IDLE, out_valid 0, result 0, iteration counter 0, operand registers 0.
- REQ-018 rst asserted in BUSY or DONE SHALL discard the operation; in_ready is high the first cycle after rst deasserts.

Configuration
- REQ-019 Macro ALU_ITER_M_EN SHALL gate the M-extension datapath.
  - Defined: REQ-006 to REQ-010 apply.
  - Undefined: M ops are treated per REQ-016 (1-cycle, result 0), BUSY is unreachable and no mul/div logic is synthesised.

Structure
- REQ-020 alu_op_e, including the M op encodings, SHALL live in the shared riscv types package; the FSM state enum is local.
- REQ-021 The iterative mul/div engine SHALL be one sub-module, alu_iter_muldiv, with ports start, op, operands, done, result.
  - It handles sign fix-up and the special cases of REQ-009 and REQ-010.
  - It is instantiated only under ALU_ITER_M_EN.

Verification (XLEN=32, ALU_ITER_M_EN defined unless noted)
- REQ-022 ADD 5+7 accepted at cycle 0 -> out_valid at cycle 1, result 12; SRA 0x80000000 by 4 -> 0xF8000000.
- REQ-023 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE at cycle 33; MULH with the same operands -> 0; MUL with the same operands -> 1.
- REQ-024 Divide cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
  - DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100.
  - DIV -7 / 2 -> 0xFFFFFFFD.
- REQ-025 Hold DONE of ADD 1+1 with out_ready low for 5 cycles -> result stays 2 and in_ready stays low. Then raise out_ready with in_valid high -> SUB accepted in the same cycle.
- REQ-026 Abort cases:
  - DIV accepted, flush pulsed in iteration 10 -> no out_valid; in_ready high the next cycle.
  - Same setup with rst instead of flush -> all outputs 0 immediately.
- REQ-027 ALU_ITER_M_EN undefined: MUL 3x4 -> out_valid at cycle 1, result 0.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: shared RISC-V ALU op encodings (base ops 0-9, M ops 16-23) and M-op classifier
package alu_iter_pkg;
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SLT    = 5'd6,
    ALU_SLTU   = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  function automatic logic is_m_op(input alu_op_e op);
    return op[4:3] == 2'b10;
  endfunction
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: radix-2 shift-add multiplier / restoring divider, XLEN iterations; ports clk, rst, flush, start, op, src_a, src_b -> done, result
module alu_iter_muldiv
  import alu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  logic            busy, neg_q, neg_r, div0, sa, sb, is_div, div_r, ok;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, dvsr, mag_a, mag_b, hi_n, lo_n;
  logic [XLEN:0]   sum, shl, diff;
  logic [2*XLEN-1:0] prod;
  alu_op_e         op_r;
  assign is_div = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign div_r  = op_r inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign sa     = (op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && src_a[XLEN-1];
  assign sb     = (op inside {ALU_MULH, ALU_DIV, ALU_REM}) && src_b[XLEN-1];
  assign mag_a  = sa ? -src_a : src_a;
  assign mag_b  = sb ? -src_b : src_b;
  // multiply: {hi,lo} is the running product with the multiplier shifting out of lo
  assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : '0);
  // divide: hi is the partial remainder, quotient bits shift into lo
  assign shl    = {hi, lo[XLEN-1]};
  assign diff   = shl - {1'b0, dvsr};
  assign ok     = !diff[XLEN];
  assign hi_n   = div_r ? (ok ? diff[XLEN-1:0] : shl[XLEN-1:0]) : sum[XLEN:1];
  assign lo_n   = div_r ? {lo[XLEN-2:0], ok} : {sum[0], lo[XLEN-1:1]};
  assign prod   = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
  assign done   = busy && cnt == CW'(XLEN - 1);
  // divide by zero yields all-ones magnitude and remainder |a|, so only the quotient
  // needs forcing; most-negative / -1 falls out of the magnitude path naturally
  always_comb
    result = op_r == ALU_MUL ? prod[XLEN-1:0]
           : op_r inside {ALU_DIV, ALU_DIVU} ? (div0 ? '1 : neg_q ? -lo_n : lo_n)
           : op_r inside {ALU_REM, ALU_REMU} ? (neg_r ? -hi_n : hi_n)
           : prod[2*XLEN-1:XLEN];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      dvsr  <= '0;
      op_r  <= ALU_ADD;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      hi    <= '0;
      lo    <= is_div ? mag_a : mag_b;
      dvsr  <= is_div ? mag_b : mag_a;
      op_r  <= op;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      div0  <= src_b == '0;
    end else if (busy) begin
      hi   <= hi_n;
      lo   <= lo_n;
      cnt  <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: valid/ready ALU, 1-cycle base ops, XLEN+1-cycle M ops when ALU_ITER_M_EN is defined; ports clk, rst, in_valid/in_ready, src_a, src_b, alu_op, flush, out_valid/out_ready, result
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  alu_op_e         alu_op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]            state;
  logic [$clog2(XLEN)-1:0] shamt;
  logic [XLEN-1:0]       base_res, md_res;
  logic                  m_op, md_done, accept;
  assign shamt = src_b[$clog2(XLEN)-1:0];
  always_comb begin
    base_res = '0;
    case (alu_op)
      ALU_ADD:  base_res = src_a + src_b;
      ALU_SUB:  base_res = src_a - src_b;
      ALU_AND:  base_res = src_a & src_b;
      ALU_OR:   base_res = src_a | src_b;
      ALU_XOR:  base_res = src_a ^ src_b;
      ALU_SLL:  base_res = src_a << shamt;
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SRL:  base_res = src_a >> shamt;
      ALU_SRA:  base_res = $signed(src_a) >>> shamt;
      default:  base_res = '0;
    endcase
  end
  // rst gates in_ready so every output reads 0 while reset is held
  assign in_ready  = !rst && !flush && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = state == DONE;
`ifdef ALU_ITER_M_EN
  assign m_op = is_m_op(alu_op);
  alu_iter_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (accept && m_op),
    .op     (alu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .done   (md_done),
    .result (md_res)
  );
`else
  assign m_op    = 1'b0;
  assign md_done = 1'b0;
  assign md_res  = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state <= m_op ? BUSY : DONE;
      if (!m_op) result <= base_res;
    end else if (state == BUSY && md_done) begin
      state  <= DONE;
      result <= md_res;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule
